// File: rtl/alu9_pkg.sv
// Shared 9-bit sign-magnitude types and helpers for the min/max pooling reducers.
// Order: any negative below any positive; -0 and +0 compare equal.
package alu9_pkg;

    typedef logic [8:0] sm9_t;

    localparam sm9_t SM9_POS_MAX = 9'h0FF;
    localparam sm9_t SM9_ZERO    = 9'h000;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } pool_state_t;

    // Strict a < b; a zero magnitude is treated as positive regardless of its sign bit.
    function automatic logic sm9_lt(input sm9_t a, input sm9_t b);
        logic a_neg;
        logic b_neg;
        a_neg = a[8] & (a[7:0] != 8'h00);
        b_neg = b[8] & (b[7:0] != 8'h00);
        if (a_neg != b_neg) begin
            sm9_lt = a_neg;
        end else if (a_neg) begin
            sm9_lt = (a[7:0] > b[7:0]);
        end else begin
            sm9_lt = (a[7:0] < b[7:0]);
        end
    endfunction

    function automatic sm9_t sm9_norm(input sm9_t a);
        sm9_norm = (a[7:0] == 8'h00) ? SM9_ZERO : a;
    endfunction

endpackage

// File: rtl/min_9bit.sv
// Two-input sign-magnitude minimum selector; on a tie the result is inputB.
module min_9bit
    import alu9_pkg::*;
(
    input  sm9_t inputA,
    input  sm9_t inputB,
    output sm9_t out,
    output logic a_lt_b
);

    logic w_a_lt_b;

    // Strict comparison so that ties keep the incumbent on inputB.
    always_comb begin
        w_a_lt_b = sm9_lt(inputA, inputB);
        if (w_a_lt_b) begin
            out = inputA;
        end else begin
            out = inputB;
        end
    end

    assign a_lt_b = w_a_lt_b;

endmodule

// File: rtl/min_pool_9bit.sv
// Streaming min-pool over WINDOW sign-magnitude samples with valid/ready on both sides.
// Optional argmin output enabled by defining MIN_POOL_ARGMIN_EN.
module min_pool_9bit
    import alu9_pkg::*;
#(
    parameter int WINDOW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out_data
`ifdef MIN_POOL_ARGMIN_EN
    ,
    output logic [7:0] out_idx
`endif
);

    localparam logic [7:0] LAST_CNT = 8'(WINDOW - 1);

    pool_state_t r_state;
    logic [7:0]  r_cnt;
    sm9_t        r_acc;
    logic        r_out_valid;
    sm9_t        r_out_data;
    sm9_t        w_min;
    logic        w_new_lt;
    logic        w_in_fire;
`ifdef MIN_POOL_ARGMIN_EN
    logic [7:0]  r_idx;
    logic [7:0]  r_out_idx;
`endif

    // New sample on A, incumbent on B, so equal values keep the earlier sample.
    min_9bit u_min (
        .inputA (in_data),
        .inputB (r_acc),
        .out    (w_min),
        .a_lt_b (w_new_lt)
    );

    // In HOLD the next window may start on the same cycle the result drains.
    assign in_ready  = (r_state == ACCUM) ? 1'b1 : out_ready;
    assign w_in_fire = in_valid & in_ready;

    // Window accumulation and result hand-off FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_cnt       <= 8'd0;
            r_acc       <= SM9_POS_MAX;
            r_out_valid <= 1'b0;
            r_out_data  <= SM9_ZERO;
`ifdef MIN_POOL_ARGMIN_EN
            r_idx       <= 8'd0;
            r_out_idx   <= 8'd0;
`endif
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_in_fire) begin
                        if (r_cnt == 8'd0) begin
                            r_acc <= in_data;
`ifdef MIN_POOL_ARGMIN_EN
                            r_idx <= 8'd0;
`endif
                        end else if (w_new_lt) begin
                            r_acc <= in_data;
`ifdef MIN_POOL_ARGMIN_EN
                            r_idx <= r_cnt;
`endif
                        end
                        if (r_cnt == LAST_CNT) begin
                            r_out_data  <= sm9_norm(w_min);
                            r_out_valid <= 1'b1;
                            r_cnt       <= 8'd0;
                            r_state     <= HOLD;
`ifdef MIN_POOL_ARGMIN_EN
                            r_out_idx   <= w_new_lt ? r_cnt : r_idx;
`endif
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ACCUM;
                        if (in_valid) begin
                            r_acc <= in_data;
                            r_cnt <= 8'd1;
`ifdef MIN_POOL_ARGMIN_EN
                            r_idx <= 8'd0;
`endif
                        end
                    end
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
`ifdef MIN_POOL_ARGMIN_EN
    assign out_idx   = r_out_idx;
`endif

endmodule

// File: tb/tb_min_pool_9bit.sv
// Scoreboard bench for min_pool_9bit (WINDOW=4); argmin checks only with MIN_POOL_ARGMIN_EN.
module tb_min_pool_9bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] in_data = 9'h000;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] out_data;
`ifdef MIN_POOL_ARGMIN_EN
    logic [7:0] out_idx;
`endif

    min_pool_9bit #(.WINDOW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef MIN_POOL_ARGMIN_EN
        ,
        .out_idx   (out_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] data;
        logic [7:0] idx;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] win[$];
    exp_t       e;
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    logic       s_in_fire, s_out_fire, s_ov, s_ir;
    logic [8:0] s_od;
    logic [7:0] s_oi;

    function automatic int sm_val(input logic [8:0] s);
        return s[8] ? -int'(s[7:0]) : int'(s[7:0]);
    endfunction

    // Reference: first sample with the smallest signed value; zero emitted as +0.
    task automatic model_window();
        int   best;
        exp_t x;
        best = 0;
        for (int i = 1; i < 4; i++) begin
            if (sm_val(win[i]) < sm_val(win[best])) best = i;
        end
        x.data = (win[best][7:0] == 8'h00) ? 9'h000 : win[best];
        x.idx  = 8'(best);
        x.cyc  = cyc + 1;
        sb.push_back(x);
        win.delete();
    endtask

    // Drive one cycle, sample between edges, feed accepted samples to the model.
    task automatic step(input logic v, input logic [8:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        s_ir       = in_ready;
        s_ov       = out_valid;
        s_od       = out_data;
`ifdef MIN_POOL_ARGMIN_EN
        s_oi       = out_idx;
`else
        s_oi       = 8'd0;
`endif
        s_in_fire  = in_valid && in_ready;
        s_out_fire = out_valid && out_ready;
        if (s_in_fire) begin
            win.push_back(d);
            if (win.size() == 4) model_window();
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        win.delete();
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_chk++; if (out_data !== 9'h000) $display("FAIL reset_out_data got=%h exp=000", out_data); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
`ifdef MIN_POOL_ARGMIN_EN
        n_chk++; if (out_idx !== 8'd0) $display("FAIL reset_out_idx got=%0d exp=0", out_idx); else n_pass++;
`endif
        @(negedge clk);
    endtask

    task automatic test_ordering();
        logic [8:0] vec [0:15];
        vec = '{9'h003, 9'h002, 9'h007, 9'h005,
                9'h101, 9'h000, 9'h103, 9'h002,
                9'h100, 9'h000, 9'h004, 9'h004,
                9'h005, 9'h005, 9'h005, 9'h005};
        for (int i = 0; i < 17; i++) begin
            if (i < 16) step(1'b1, vec[i], 1'b1);
            else        step(1'b0, 9'h000, 1'b1);
            if (s_out_fire) begin
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL order_unexpected_out got=%h exp=none", s_od);
                end else begin
                    e = sb.pop_front();
                    if (s_od !== e.data) $display("FAIL order_data got=%h exp=%h", s_od, e.data);
                    else n_pass++;
`ifdef MIN_POOL_ARGMIN_EN
                    n_chk++; if (s_oi !== e.idx) $display("FAIL order_idx got=%0d exp=%0d", s_oi, e.idx); else n_pass++;
`endif
                    n_chk++; if (cyc - 1 !== e.cyc) $display("FAIL order_latency got=%0d exp=%0d", cyc - 1, e.cyc); else n_pass++;
                end
            end
        end
        n_chk++; if (sb.size() !== 0) $display("FAIL order_missing got=%0d exp=0", sb.size()); else n_pass++;
    endtask

    task automatic test_stall();
        logic [8:0] vec [0:3];
        vec = '{9'h006, 9'h102, 9'h003, 9'h102};
        for (int i = 0; i < 4; i++) step(1'b1, vec[i], 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 9'h007, 1'b0);
            n_chk++; if (s_ir !== 1'b0) $display("FAIL stall_in_ready got=%b exp=0", s_ir); else n_pass++;
            n_chk++; if (s_ov !== 1'b1) $display("FAIL stall_out_valid got=%b exp=1", s_ov); else n_pass++;
            n_chk++; if (sb.size() == 0 || s_od !== sb[0].data) $display("FAIL stall_out_data got=%h exp=102", s_od); else n_pass++;
        end
        step(1'b1, 9'h007, 1'b1);
        n_chk++; if (s_in_fire !== 1'b1) $display("FAIL stall_restart_in got=%b exp=1", s_in_fire); else n_pass++;
        n_chk++;
        if (!s_out_fire || sb.size() == 0) begin
            $display("FAIL stall_release got=%b exp=1", s_out_fire);
        end else begin
            e = sb.pop_front();
            if (s_od !== e.data) $display("FAIL stall_data got=%h exp=%h", s_od, e.data); else n_pass++;
`ifdef MIN_POOL_ARGMIN_EN
            n_chk++; if (s_oi !== e.idx) $display("FAIL stall_idx got=%0d exp=%0d", s_oi, e.idx); else n_pass++;
`endif
        end
        vec = '{9'h001, 9'h009, 9'h002, 9'h000};
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(1'b1, vec[i], 1'b1);
            else       step(1'b0, 9'h000, 1'b1);
            if (s_out_fire) begin
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL stall_unexpected_out got=%h exp=none", s_od);
                end else begin
                    e = sb.pop_front();
                    if (s_od !== e.data) $display("FAIL stall2_data got=%h exp=%h", s_od, e.data); else n_pass++;
                end
            end
        end
        n_chk++; if (sb.size() !== 0) $display("FAIL stall_missing got=%0d exp=0", sb.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n_out;
        n_out = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) step(1'b1, 9'($urandom_range(0, 511)), 1'b1);
            else       step(1'b0, 9'h000, 1'b1);
            if (i < 8) begin
                n_chk++; if (s_in_fire !== 1'b1) $display("FAIL b2b_in_fire got=%b exp=1", s_in_fire); else n_pass++;
            end
            if (s_out_fire) begin
                n_out++;
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL b2b_unexpected_out got=%h exp=none", s_od);
                end else begin
                    e = sb.pop_front();
                    if (s_od !== e.data) $display("FAIL b2b_data got=%h exp=%h", s_od, e.data); else n_pass++;
                    n_chk++; if (cyc - 1 !== e.cyc) $display("FAIL b2b_latency got=%0d exp=%0d", cyc - 1, e.cyc); else n_pass++;
`ifdef MIN_POOL_ARGMIN_EN
                    n_chk++; if (s_oi !== e.idx) $display("FAIL b2b_idx got=%0d exp=%0d", s_oi, e.idx); else n_pass++;
`endif
                end
            end
        end
        n_chk++; if (n_out !== 2) $display("FAIL b2b_result_count got=%0d exp=2", n_out); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [8:0] vec [0:3];
        int n_out;
        n_out = 0;
        step(1'b1, 9'h001, 1'b1);
        step(1'b1, 9'h101, 1'b1);
        apply_reset();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL mid_reset_valid got=%b exp=0", out_valid); else n_pass++;
        vec = '{9'h009, 9'h008, 9'h009, 9'h009};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) step(1'b1, vec[i], 1'b1);
            else       step(1'b0, 9'h000, 1'b1);
            if (s_out_fire) begin
                n_out++;
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL mid_unexpected_out got=%h exp=none", s_od);
                end else begin
                    e = sb.pop_front();
                    if (s_od !== e.data) $display("FAIL mid_data got=%h exp=%h", s_od, e.data); else n_pass++;
`ifdef MIN_POOL_ARGMIN_EN
                    n_chk++; if (s_oi !== e.idx) $display("FAIL mid_idx got=%0d exp=%0d", s_oi, e.idx); else n_pass++;
`endif
                end
            end
        end
        n_chk++; if (n_out !== 1) $display("FAIL mid_result_count got=%0d exp=1", n_out); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
